// File: rtl/risk_pkg.sv
// Shared constants and types for the operand fetch stage.
//   XLEN      : register / operand width
//   NREG      : number of architectural registers (x0 reads as zero)
//   REGW      : register index width
//   reg_idx_t : register index type
//   state_e   : operand fetch sequencing states
package risk_pkg;
  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int REGW = $clog2(NREG);

  typedef logic [REGW-1:0] reg_idx_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    READ  = 2'd2,
    OUT   = 2'd3
  } state_e;
endpackage

// File: rtl/operand_fetch_if.sv
// Bundle of every non-clock signal of the operand fetch stage.
//   decode side    : in_valid/in_ready, in_rs1, in_rs2, in_rdst, in_wen
//   execute side   : out_valid/out_ready, out_op1, out_op2, out_rdst, out_wen
//   writeback side : wb_valid, wb_sel, wb_val (never back-pressured)
//   regfile side   : rf_wr/rf_selwr/rf_wrval, rf_rd/rf_selrd1/rf_selrd2,
//                    rf_rdval1/rf_rdval2 (valid the cycle after rf_rd)
// master : the operand fetch block (requester of the regfile)
// slave  : its environment (decode, execute, regfile)
interface operand_fetch_if;
  import risk_pkg::*;

  logic            in_valid;
  logic            in_ready;
  reg_idx_t        in_rs1;
  reg_idx_t        in_rs2;
  reg_idx_t        in_rdst;
  logic            in_wen;

  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_op1;
  logic [XLEN-1:0] out_op2;
  reg_idx_t        out_rdst;
  logic            out_wen;

  logic            wb_valid;
  reg_idx_t        wb_sel;
  logic [XLEN-1:0] wb_val;

  logic            rf_wr;
  reg_idx_t        rf_selwr;
  logic [XLEN-1:0] rf_wrval;
  logic            rf_rd;
  reg_idx_t        rf_selrd1;
  reg_idx_t        rf_selrd2;
  logic [XLEN-1:0] rf_rdval1;
  logic [XLEN-1:0] rf_rdval2;

  modport master (
    input  in_valid, in_rs1, in_rs2, in_rdst, in_wen,
    output in_ready,
    output out_valid, out_op1, out_op2, out_rdst, out_wen,
    input  out_ready,
    input  wb_valid, wb_sel, wb_val,
    output rf_wr, rf_selwr, rf_wrval, rf_rd, rf_selrd1, rf_selrd2,
    input  rf_rdval1, rf_rdval2
  );

  modport slave (
    output in_valid, in_rs1, in_rs2, in_rdst, in_wen,
    input  in_ready,
    input  out_valid, out_op1, out_op2, out_rdst, out_wen,
    output out_ready,
    output wb_valid, wb_sel, wb_val,
    input  rf_wr, rf_selwr, rf_wrval, rf_rd, rf_selrd1, rf_selrd2,
    output rf_rdval1, rf_rdval2
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// Busy scoreboard for registers 1..NREG-1; register 0 always reads not-busy.
//   clk, rst         : clock, asynchronous active-low reset (clears all bits)
//   set_en, set_idx  : mark a register busy at the next edge
//   clr_en, clr_idx  : mark a register free at the next edge
//   look_a/b/c       : lookup indices
//   busy_a/b/c       : combinational busy state of the looked-up registers
// When set and clear hit the same bit on one edge the set wins, so a new
// producer issued in the cycle an older one writes back stays tracked.
module regfile_scoreboard
  import risk_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     set_en,
  input  reg_idx_t set_idx,
  input  logic     clr_en,
  input  reg_idx_t clr_idx,
  input  reg_idx_t look_a,
  input  reg_idx_t look_b,
  input  reg_idx_t look_c,
  output logic     busy_a,
  output logic     busy_b,
  output logic     busy_c
);
  logic [NREG-1:1] busy_q;
  logic [NREG-1:1] busy_d;
  logic [NREG-1:0] busy_vec;

  always_comb begin
    busy_d = busy_q;
    for (int i = 1; i < NREG; i++) begin
      if (clr_en && (clr_idx == reg_idx_t'(i))) busy_d[i] = 1'b0;
      if (set_en && (set_idx == reg_idx_t'(i))) busy_d[i] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) busy_q <= '0;
    else      busy_q <= busy_d;
  end

  assign busy_vec = {busy_q, 1'b0};
  assign busy_a   = busy_vec[look_a];
  assign busy_b   = busy_vec[look_b];
  assign busy_c   = busy_vec[look_c];
endmodule

// File: rtl/operand_fetch.sv
// Operand fetch stage: accepts decoded register indices, stalls on RAW/WAW
// hazards using a busy scoreboard, reads the regfile and hands the operand
// pair to execute. Execute writebacks are forwarded to the regfile write port.
//   clk, rst : clock, asynchronous active-low reset
//   bus      : operand_fetch_if.master (decode, execute, writeback, regfile)
// Sequence: IDLE/OUT --accept--> CHECK --no hazard, rf_rd--> READ --> OUT.
// Optional macro BYPASS_EN: a busy source being written back in the CHECK
// cycle is taken from the writeback bus instead of waiting for the regfile.
module operand_fetch
  import risk_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  operand_fetch_if.master bus
);
  state_e          state_q, state_d;
  reg_idx_t        rs1_q, rs1_d, rs2_q, rs2_d, rdst_q, rdst_d;
  logic            wen_q, wen_d;
  logic [XLEN-1:0] out_op1_q, out_op1_d, out_op2_q, out_op2_d;
  reg_idx_t        out_rdst_q, out_rdst_d;
  logic            out_wen_q, out_wen_d;

  logic            in_ready;
  logic            busy_rs1, busy_rs2, busy_rdst;
  logic            blk_rs1, blk_rs2, hazard;
  logic            set_en;
  logic [XLEN-1:0] rd_op1, rd_op2;

  regfile_scoreboard u_scoreboard (
    .clk     (clk),
    .rst     (rst),
    .set_en  (set_en),
    .set_idx (rdst_q),
    .clr_en  (bus.wb_valid),
    .clr_idx (bus.wb_sel),
    .look_a  (rs1_q),
    .look_b  (rs2_q),
    .look_c  (rdst_q),
    .busy_a  (busy_rs1),
    .busy_b  (busy_rs2),
    .busy_c  (busy_rdst)
  );

`ifdef BYPASS_EN
  logic            hit_rs1, hit_rs2;
  logic            byp1_q, byp1_d, byp2_q, byp2_d;
  logic [XLEN-1:0] byp_val_q, byp_val_d;

  // Only a busy source can hit; a non-busy source already has its value
  // in the regfile.
  assign hit_rs1 = busy_rs1 & bus.wb_valid & (bus.wb_sel == rs1_q);
  assign hit_rs2 = busy_rs2 & bus.wb_valid & (bus.wb_sel == rs2_q);
  assign blk_rs1 = busy_rs1 & ~hit_rs1;
  assign blk_rs2 = busy_rs2 & ~hit_rs2;
  assign rd_op1  = byp1_q ? byp_val_q : bus.rf_rdval1;
  assign rd_op2  = byp2_q ? byp_val_q : bus.rf_rdval2;
`else
  assign blk_rs1 = busy_rs1;
  assign blk_rs2 = busy_rs2;
  assign rd_op1  = bus.rf_rdval1;
  assign rd_op2  = bus.rf_rdval2;
`endif

  // WAW is never bypassed: the older write must land first.
  assign hazard   = blk_rs1 | blk_rs2 | (wen_q & busy_rdst);
  assign in_ready = (state_q == IDLE) | ((state_q == OUT) & bus.out_ready);

  always_comb begin
    state_d       = state_q;
    rs1_d         = rs1_q;
    rs2_d         = rs2_q;
    rdst_d        = rdst_q;
    wen_d         = wen_q;
    out_op1_d     = out_op1_q;
    out_op2_d     = out_op2_q;
    out_rdst_d    = out_rdst_q;
    out_wen_d     = out_wen_q;
    set_en        = 1'b0;
    bus.rf_rd     = 1'b0;
    bus.rf_selrd1 = '0;
    bus.rf_selrd2 = '0;
`ifdef BYPASS_EN
    byp1_d        = byp1_q;
    byp2_d        = byp2_q;
    byp_val_d     = byp_val_q;
`endif

    case (state_q)
      IDLE: ;
      CHECK: begin
        if (!hazard) begin
          bus.rf_rd     = 1'b1;
          bus.rf_selrd1 = rs1_q;
          bus.rf_selrd2 = rs2_q;
          state_d       = READ;
`ifdef BYPASS_EN
          byp1_d        = hit_rs1;
          byp2_d        = hit_rs2;
          byp_val_d     = bus.wb_val;
`endif
        end
      end
      READ: begin
        out_op1_d  = (rs1_q == '0) ? '0 : rd_op1;
        out_op2_d  = (rs2_q == '0) ? '0 : rd_op2;
        out_rdst_d = rdst_q;
        out_wen_d  = wen_q;
        set_en     = wen_q & (rdst_q != '0);
        state_d    = OUT;
      end
      OUT: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Acceptance overrides the OUT->IDLE exit so a waiting instruction
    // enters CHECK in the same cycle execute takes the current one.
    if (bus.in_valid && in_ready) begin
      rs1_d   = bus.in_rs1;
      rs2_d   = bus.in_rs2;
      rdst_d  = bus.in_rdst;
      wen_d   = bus.in_wen;
      state_d = CHECK;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      rs1_q      <= '0;
      rs2_q      <= '0;
      rdst_q     <= '0;
      wen_q      <= 1'b0;
      out_op1_q  <= '0;
      out_op2_q  <= '0;
      out_rdst_q <= '0;
      out_wen_q  <= 1'b0;
`ifdef BYPASS_EN
      byp1_q     <= 1'b0;
      byp2_q     <= 1'b0;
      byp_val_q  <= '0;
`endif
    end else begin
      state_q    <= state_d;
      rs1_q      <= rs1_d;
      rs2_q      <= rs2_d;
      rdst_q     <= rdst_d;
      wen_q      <= wen_d;
      out_op1_q  <= out_op1_d;
      out_op2_q  <= out_op2_d;
      out_rdst_q <= out_rdst_d;
      out_wen_q  <= out_wen_d;
`ifdef BYPASS_EN
      byp1_q     <= byp1_d;
      byp2_q     <= byp2_d;
      byp_val_q  <= byp_val_d;
`endif
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = (state_q == OUT);
  assign bus.out_op1   = out_op1_q;
  assign bus.out_op2   = out_op2_q;
  assign bus.out_rdst  = out_rdst_q;
  assign bus.out_wen   = out_wen_q;

  assign bus.rf_wr     = bus.wb_valid & (bus.wb_sel != '0);
  assign bus.rf_selwr  = bus.wb_sel;
  assign bus.rf_wrval  = bus.wb_val;
endmodule

// File: tb/tb_operand_fetch.sv
// Directed testbench for operand_fetch with a behavioural regfile that
// returns read data the cycle after rf_rd (optionally forced to garbage).
module tb_operand_fetch;
  import risk_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic garbage = 1'b0;
  int   checks = 0;
  int   errors = 0;

`ifdef BYPASS_EN
  localparam int   RAW_LAT = 2;
  localparam logic BYP_RD  = 1'b1;
`else
  localparam int   RAW_LAT = 3;
  localparam logic BYP_RD  = 1'b0;
`endif

  always #5 clk = ~clk;

  operand_fetch_if ifc();

  operand_fetch dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  logic [XLEN-1:0] mem [NREG];

  always @(posedge clk) begin
    if (ifc.rf_wr) mem[ifc.rf_selwr] <= ifc.rf_wrval;
    if (ifc.rf_rd) begin
      ifc.rf_rdval1 <= garbage ? 32'hDEAD_BEEF : mem[ifc.rf_selrd1];
      ifc.rf_rdval2 <= garbage ? 32'hCAFE_F00D : mem[ifc.rf_selrd2];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input reg_idx_t rs1, input reg_idx_t rs2,
                       input reg_idx_t rdst, input logic wen);
    ifc.in_valid = 1'b1;
    ifc.in_rs1   = rs1;
    ifc.in_rs2   = rs2;
    ifc.in_rdst  = rdst;
    ifc.in_wen   = wen;
    tick();
    ifc.in_valid = 1'b0;
  endtask

  task automatic consume();
    ifc.out_ready = 1'b1;
    tick();
    ifc.out_ready = 1'b0;
  endtask

  task automatic wb_pulse(input reg_idx_t sel, input logic [XLEN-1:0] val);
    ifc.wb_valid = 1'b1;
    ifc.wb_sel   = sel;
    ifc.wb_val   = val;
    tick();
    ifc.wb_valid = 1'b0;
  endtask

  task automatic test_reset();
    #1 rst = 1'b0;
    #1;
    checks++;
    if ({ifc.out_valid, ifc.rf_rd, ifc.out_wen, ifc.out_rdst, ifc.rf_selrd1, ifc.rf_selrd2} !== '0) begin
      errors++;
      $display("FAIL reset_ctrl got valid=%0b rd=%0b wen=%0b rdst=%0d sel1=%0d sel2=%0d expected all 0",
               ifc.out_valid, ifc.rf_rd, ifc.out_wen, ifc.out_rdst, ifc.rf_selrd1, ifc.rf_selrd2);
    end
    checks++;
    if (ifc.out_op1 !== 32'd0 || ifc.out_op2 !== 32'd0) begin
      errors++;
      $display("FAIL reset_ops got op1=%h op2=%h expected 0 0", ifc.out_op1, ifc.out_op2);
    end
    checks++;
    if (ifc.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready got %b expected 1", ifc.in_ready);
    end
    $display("reset: checked idle outputs");
    tick();
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic test_write_path();
    ifc.wb_valid = 1'b1;
    ifc.wb_sel   = 5'd0;
    ifc.wb_val   = 32'd5;
    #1;
    checks++;
    if (ifc.rf_wr !== 1'b0) begin
      errors++;
      $display("FAIL wr_x0 got rf_wr=%b expected 0", ifc.rf_wr);
    end
    ifc.wb_sel = 5'd9;
    ifc.wb_val = 32'h1234;
    #1;
    checks++;
    if (ifc.rf_wr !== 1'b1 || ifc.rf_selwr !== 5'd9 || ifc.rf_wrval !== 32'h1234) begin
      errors++;
      $display("FAIL wr_x9 got wr=%b sel=%0d val=%h expected 1 9 1234",
               ifc.rf_wr, ifc.rf_selwr, ifc.rf_wrval);
    end
    tick();
    ifc.wb_valid = 1'b0;
    wb_pulse(5'd1, 32'd10);
    wb_pulse(5'd2, 32'd21);
    wb_pulse(5'd5, 32'd55);
    $display("write_path: x0 suppressed, x9/x1/x2/x5 written");
  endtask

  task automatic test_basic();
    issue(5'd1, 5'd2, 5'd5, 1'b0);
    checks++;
    if (ifc.rf_rd !== 1'b1 || ifc.rf_selrd1 !== 5'd1 || ifc.rf_selrd2 !== 5'd2 || ifc.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_rd got rd=%b sel1=%0d sel2=%0d valid=%b expected 1 1 2 0",
               ifc.rf_rd, ifc.rf_selrd1, ifc.rf_selrd2, ifc.out_valid);
    end
    tick();
    checks++;
    if (ifc.rf_rd !== 1'b0 || ifc.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_read_cycle got rd=%b valid=%b expected 0 0", ifc.rf_rd, ifc.out_valid);
    end
    tick();
    checks++;
    if (ifc.out_valid !== 1'b1 || ifc.out_op1 !== 32'd10 || ifc.out_op2 !== 32'd21 ||
        ifc.out_rdst !== 5'd5 || ifc.out_wen !== 1'b0) begin
      errors++;
      $display("FAIL basic_out got valid=%b op1=%0d op2=%0d rdst=%0d wen=%b expected 1 10 21 5 0",
               ifc.out_valid, ifc.out_op1, ifc.out_op2, ifc.out_rdst, ifc.out_wen);
    end
    consume();
    $display("basic: op1=%0d op2=%0d", ifc.out_op1, ifc.out_op2);
  endtask

  task automatic test_raw();
    int cycles;
    issue(5'd0, 5'd0, 5'd3, 1'b1);
    tick();
    tick();
    checks++;
    if (ifc.out_wen !== 1'b1 || ifc.out_rdst !== 5'd3) begin
      errors++;
      $display("FAIL raw_producer got wen=%b rdst=%0d expected 1 3", ifc.out_wen, ifc.out_rdst);
    end
    consume();
    issue(5'd3, 5'd1, 5'd0, 1'b0);
    checks++;
    if (ifc.rf_rd !== 1'b0) begin
      errors++;
      $display("FAIL raw_stall0 got rf_rd=%b expected 0", ifc.rf_rd);
    end
    tick();
    checks++;
    if (ifc.rf_rd !== 1'b0) begin
      errors++;
      $display("FAIL raw_stall1 got rf_rd=%b expected 0", ifc.rf_rd);
    end
    ifc.wb_valid = 1'b1;
    ifc.wb_sel   = 5'd3;
    ifc.wb_val   = 32'd7;
    #1;
    checks++;
    if (ifc.rf_rd !== BYP_RD) begin
      errors++;
      $display("FAIL raw_wb_cycle got rf_rd=%b expected %b", ifc.rf_rd, BYP_RD);
    end
    tick();
    ifc.wb_valid = 1'b0;
    cycles = 1;
    while (ifc.out_valid !== 1'b1 && cycles < 10) begin
      tick();
      cycles++;
    end
    checks++;
    if (cycles != RAW_LAT) begin
      errors++;
      $display("FAIL raw_latency got %0d cycles after wb expected %0d", cycles, RAW_LAT);
    end
    checks++;
    if (ifc.out_op1 !== 32'd7 || ifc.out_op2 !== 32'd10) begin
      errors++;
      $display("FAIL raw_ops got op1=%0d op2=%0d expected 7 10", ifc.out_op1, ifc.out_op2);
    end
    consume();
    $display("raw: wb-to-out %0d cycles op1=%0d", cycles, ifc.out_op1);
  endtask

  task automatic test_zero_src();
    garbage = 1'b1;
    issue(5'd0, 5'd0, 5'd0, 1'b1);
    checks++;
    if (ifc.rf_rd !== 1'b1) begin
      errors++;
      $display("FAIL zero_no_stall got rf_rd=%b expected 1", ifc.rf_rd);
    end
    tick();
    tick();
    checks++;
    if (ifc.out_op1 !== 32'd0 || ifc.out_op2 !== 32'd0) begin
      errors++;
      $display("FAIL zero_ops got op1=%h op2=%h expected 0 0", ifc.out_op1, ifc.out_op2);
    end
    consume();
    issue(5'd2, 5'd0, 5'd0, 1'b1);
    checks++;
    if (ifc.rf_rd !== 1'b1) begin
      errors++;
      $display("FAIL zero_rdst_busy got rf_rd=%b expected 1", ifc.rf_rd);
    end
    tick();
    tick();
    checks++;
    if (ifc.out_op1 !== 32'hDEAD_BEEF || ifc.out_op2 !== 32'd0) begin
      errors++;
      $display("FAIL zero_mixed got op1=%h op2=%h expected deadbeef 0", ifc.out_op1, ifc.out_op2);
    end
    consume();
    garbage = 1'b0;
    $display("zero_src: x0 operands forced to 0");
  endtask

  task automatic test_back_to_back();
    issue(5'd1, 5'd2, 5'd6, 1'b0);
    tick();
    tick();
    ifc.in_valid = 1'b1;
    ifc.in_rs1   = 5'd2;
    ifc.in_rs2   = 5'd1;
    ifc.in_rdst  = 5'd7;
    ifc.in_wen   = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if (ifc.out_valid !== 1'b1 || ifc.out_op1 !== 32'd10 || ifc.out_op2 !== 32'd21 || ifc.in_ready !== 1'b0) begin
        errors++;
        $display("FAIL hold_%0d got valid=%b op1=%0d op2=%0d in_ready=%b expected 1 10 21 0",
                 i, ifc.out_valid, ifc.out_op1, ifc.out_op2, ifc.in_ready);
      end
      tick();
    end
    ifc.out_ready = 1'b1;
    #1;
    checks++;
    if (ifc.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL release_in_ready got %b expected 1", ifc.in_ready);
    end
    tick();
    ifc.in_valid  = 1'b0;
    ifc.out_ready = 1'b0;
    checks++;
    if (ifc.out_valid !== 1'b0 || ifc.rf_rd !== 1'b1 || ifc.rf_selrd1 !== 5'd2 || ifc.rf_selrd2 !== 5'd1) begin
      errors++;
      $display("FAIL b2b_accept got valid=%b rd=%b sel1=%0d sel2=%0d expected 0 1 2 1",
               ifc.out_valid, ifc.rf_rd, ifc.rf_selrd1, ifc.rf_selrd2);
    end
    tick();
    tick();
    checks++;
    if (ifc.out_valid !== 1'b1 || ifc.out_op1 !== 32'd21 || ifc.out_op2 !== 32'd10 || ifc.out_rdst !== 5'd7) begin
      errors++;
      $display("FAIL b2b_out got valid=%b op1=%0d op2=%0d rdst=%0d expected 1 21 10 7",
               ifc.out_valid, ifc.out_op1, ifc.out_op2, ifc.out_rdst);
    end
    consume();
    $display("back_to_back: held 5 cycles, next accepted on release");
  endtask

  task automatic test_waw();
    int cycles;
    issue(5'd0, 5'd0, 5'd4, 1'b1);
    tick();
    tick();
    consume();
    issue(5'd1, 5'd0, 5'd4, 1'b1);
    checks++;
    if (ifc.rf_rd !== 1'b0) begin
      errors++;
      $display("FAIL waw_stall0 got rf_rd=%b expected 0", ifc.rf_rd);
    end
    tick();
    ifc.wb_valid = 1'b1;
    ifc.wb_sel   = 5'd4;
    ifc.wb_val   = 32'd99;
    #1;
    checks++;
    if (ifc.rf_rd !== 1'b0) begin
      errors++;
      $display("FAIL waw_wb_cycle got rf_rd=%b expected 0", ifc.rf_rd);
    end
    tick();
    ifc.wb_valid = 1'b0;
    #1;
    checks++;
    if (ifc.rf_rd !== 1'b1) begin
      errors++;
      $display("FAIL waw_release got rf_rd=%b expected 1", ifc.rf_rd);
    end
    tick();
    ifc.wb_valid = 1'b1;
    ifc.wb_sel   = 5'd4;
    ifc.wb_val   = 32'd55;
    tick();
    ifc.wb_valid = 1'b0;
    checks++;
    if (ifc.out_valid !== 1'b1 || ifc.out_op1 !== 32'd10 || ifc.out_rdst !== 5'd4) begin
      errors++;
      $display("FAIL waw_out got valid=%b op1=%0d rdst=%0d expected 1 10 4",
               ifc.out_valid, ifc.out_op1, ifc.out_rdst);
    end
    consume();
    issue(5'd4, 5'd0, 5'd0, 1'b0);
    tick();
    checks++;
    if (ifc.rf_rd !== 1'b0) begin
      errors++;
      $display("FAIL set_wins got rf_rd=%b expected 0 (x4 still busy)", ifc.rf_rd);
    end
    wb_pulse(5'd4, 32'd77);
    cycles = 1;
    while (ifc.out_valid !== 1'b1 && cycles < 10) begin
      tick();
      cycles++;
    end
    checks++;
    if (ifc.out_valid !== 1'b1 || ifc.out_op1 !== 32'd77) begin
      errors++;
      $display("FAIL waw_final got valid=%b op1=%0d expected 1 77", ifc.out_valid, ifc.out_op1);
    end
    consume();
    $display("waw: stalled on x4, set-wins kept x4 busy, op1=%0d", ifc.out_op1);
  endtask

  task automatic test_reset_mid();
    issue(5'd0, 5'd0, 5'd5, 1'b1);
    tick();
    tick();
    consume();
    issue(5'd5, 5'd0, 5'd0, 1'b0);
    tick();
    checks++;
    if (ifc.rf_rd !== 1'b0) begin
      errors++;
      $display("FAIL mid_stall got rf_rd=%b expected 0", ifc.rf_rd);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (ifc.out_valid !== 1'b0 || ifc.in_ready !== 1'b1 || ifc.rf_rd !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset got valid=%b in_ready=%b rd=%b expected 0 1 0",
               ifc.out_valid, ifc.in_ready, ifc.rf_rd);
    end
    tick();
    rst = 1'b1;
    tick();
    issue(5'd5, 5'd0, 5'd0, 1'b0);
    checks++;
    if (ifc.rf_rd !== 1'b1) begin
      errors++;
      $display("FAIL mid_busy_cleared got rf_rd=%b expected 1", ifc.rf_rd);
    end
    tick();
    tick();
    checks++;
    if (ifc.out_valid !== 1'b1 || ifc.out_op1 !== 32'd55) begin
      errors++;
      $display("FAIL mid_out got valid=%b op1=%0d expected 1 55", ifc.out_valid, ifc.out_op1);
    end
    consume();
    $display("reset_mid: busy cleared, x5 read as %0d", ifc.out_op1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    ifc.in_valid  = 1'b0;
    ifc.in_rs1    = '0;
    ifc.in_rs2    = '0;
    ifc.in_rdst   = '0;
    ifc.in_wen    = 1'b0;
    ifc.out_ready = 1'b0;
    ifc.wb_valid  = 1'b0;
    ifc.wb_sel    = '0;
    ifc.wb_val    = '0;
    test_reset();
    test_write_path();
    test_basic();
    test_raw();
    test_zero_src();
    test_back_to_back();
    test_waw();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/operand_fetch.md
Name: operand_fetch

Overview:
- Drives the register file's read/write ports on behalf of the pipeline; it is the requester side of the regfile interface.
- Accepts decoded register indices from decode and issues regfile reads.
- Returns the operand pair to execute over a valid/ready handshake.
- Routes execute writebacks into the regfile write port and keeps a busy scoreboard that stalls RAW and WAW hazards.

Parameters:
XLEN, 32, data width of registers and operands
NREG, 32, number of architectural registers; REGW = $clog2(NREG) (5); register 0 hard-wired zero

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  asynchronous, active-low reset
in_valid  in  1  decode presents an instruction
in_ready  out  1  block accepts instruction this cycle
in_rs1  in  REGW  source index 1
in_rs2  in  REGW  source index 2
in_rdst  in  REGW  destination index
in_wen  in  1  instruction writes in_rdst
out_valid  out  1  operands valid for execute
out_ready  in  1  execute accepts operands
out_op1  out  XLEN  operand 1
out_op2  out  XLEN  operand 2
out_rdst  out  REGW  destination passed through
out_wen  out  1  write-enable passed through
wb_valid  in  1  execute writeback strobe; always accepted, no backpressure
wb_sel  in  REGW  writeback index
wb_val  in  XLEN  writeback value
rf_wr  out  1  regfile write strobe
rf_selwr  out  REGW  regfile write index
rf_wrval  out  XLEN  regfile write data
rf_rd  out  1  regfile read strobe
rf_selrd1  out  REGW  regfile read index 1
rf_selrd2  out  REGW  regfile read index 2
rf_rdval1  in  XLEN  regfile read data 1, valid the cycle after rf_rd
rf_rdval2  in  XLEN  regfile read data 2, valid the cycle after rf_rd

Behaviour:
- Reset (rst=0, async):
  - state=IDLE and busy=0.
  - out_valid=0; out_op1, out_op2, out_rdst and out_wen are 0.
  - rf_rd=0; rf_sel* are 0.
- Write path (combinational):
  - rf_wr = wb_valid & (wb_sel!=0).
  - rf_selwr = wb_sel; rf_wrval = wb_val.
- Scoreboard busy[NREG-1:1]; busy[0] reads 0.
  - wb_valid clears busy[wb_sel] at the edge.
  - Set happens in READ (below).
  - Set and clear of the same bit on the same edge: set wins.
- in_ready = (state==IDLE) | (state==OUT & out_ready).
  - Accepting latches rs1, rs2, rdst and wen, then goes to CHECK.
- CHECK:
  - hazard = busy[rs1] | busy[rs2] | (wen & busy[rdst]).
  - Hazard: stay in CHECK, rf_rd=0.
  - No hazard: rf_rd=1, rf_selrd1=rs1, rf_selrd2=rs2, go to READ.
- READ:
  - Capture rf_rdval1/2 into out_op1/2; a source index of 0 yields 0 regardless of regfile data.
  - If wen & rdst!=0, set busy[rdst].
  - Go to OUT.
- OUT:
  - out_valid=1; outputs are held stable until out_ready.
  - out_ready & in_valid: go to CHECK with the new instruction.
  - out_ready & !in_valid: go to IDLE.
- Latency: accept→out_valid is 2 cycles with no hazard. Throughput is one instruction per 3 cycles.
- Writeback to a non-busy register is legal. It is written to the regfile, and the scoreboard is unchanged.
- Reset mid-operation discards the latched instruction and all busy bits.

Optional Feature:
- Macro BYPASS_EN.
- Defined:
  - In CHECK, a busy source whose wb_valid & wb_sel match this cycle is not a hazard.
  - wb_val is captured into a bypass register and substituted for that operand in READ.
  - If both sources match, both are substituted.
  - WAW is still stalled.
- Undefined:
  - The source waits one extra cycle for busy to clear, then issues the read.

Decomposition:
- Package risk_pkg holds:
  - XLEN and REGW constants.
  - Typedef reg_idx_t [REGW-1:0].
  - State enum IDLE/CHECK/READ/OUT.
- Sub-module regfile_scoreboard holds the busy vector:
  - Inputs: set_en/set_idx and clr_en/clr_idx, with set-wins priority.
  - Outputs: three combinational busy lookups.

Test Plan:
- Reset, then write 10 to x1 and 21 to x2 via wb; issue rs1=1, rs2=2 → rf_rd pulse then out_valid with op1=10, op2=21, 2 cycles after accept.
- Issue rdst=3 wen=1, then rs1=3 → stalls in CHECK until wb_sel=3, wb_val=7; op1=7. BYPASS_EN saves exactly 1 cycle versus without.
- rs1=0, rs2=0 while the regfile returns garbage → op1=op2=0; wen with rdst=0 never sets busy.
- out_ready held low 5 cycles → outputs stable, in_ready=0; release with in_valid high → next instruction accepted same cycle.
- WAW: rdst=4 pending, second instruction rdst=4 → stalls until wb_sel=4. Simultaneous set/clear of busy[4] leaves busy[4]=1.
- Assert rst mid-CHECK with busy[5]=1 → out_valid=0, busy=0, in_ready=1 after release.
